// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round arithmetic for sha256_multiblock.
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] STD_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StAccum,
        StWrite,
        StDone
    } state_e;

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message-schedule functions (lower-case sigma).
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] sha256_op(input logic [255:0] s, input logic [31:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] s0, s1, ch, maj, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        s1  = rightrotate(e, 6) ^ rightrotate(e, 11) ^ rightrotate(e, 25);
        ch  = (e & f) ^ (~e & g);
        t1  = h + s1 + ch + k + w;
        s0  = rightrotate(a, 2) ^ rightrotate(a, 13) ^ rightrotate(a, 22);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t2  = s0 + maj;
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: {a..h}, W[t] and t in, next {a..h} out.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_w,
    input  logic [5:0]   i_t,
    output logic [255:0] o_state
);

    assign o_state = sha256_op(i_state, i_w, K[i_t]);

endmodule

// File: rtl/sha256_multiblock.sv
// Multi-block SHA-256 engine: streams a word message from memory, pads it in hardware,
// compresses one round per cycle and writes the 8-word digest back to memory.
module sha256_multiblock
    import sha256_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              use_iv,
    input  logic [255:0]      iv_in,
    output logic              busy,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    state_e            r_state;
    logic [5:0]        r_cnt;
    logic [ADDR_W-1:0] r_block;
    logic [ADDR_W-1:0] r_nblocks;
    logic [ADDR_W-1:0] r_msg_addr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_num_words;
    logic [255:0]      r_h;
    logic [255:0]      r_s;
    logic [31:0]       r_w [16];
    logic              r_busy;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [255:0]      w_round_out;
    logic [255:0]      w_h_sum;
    logic [31:0]       w_w_next;
    logic [31:0]       w_pad;
    logic [31:0]       w_cap_idx;
    logic [31:0]       w_rd_idx;
    logic [31:0]       w_total;
    logic [31:0]       w_nw;
    logic [63:0]       w_len;
    logic [ADDR_W-1:0] w_next_block;
    logic [31:0]       w_next_base;
    logic [ADDR_W-1:0] w_start_nblocks;

    assign mem_clk        = clk;
    assign busy           = r_busy;
    assign done           = r_done;
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_write_data = r_wdata;

    sha256_round u_round (
        .i_state (r_s),
        .i_w     (r_w[0]),
        .i_t     (r_cnt),
        .o_state (w_round_out)
    );

    assign w_w_next        = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];
    assign w_nw            = 32'(r_num_words);
    assign w_cap_idx       = (32'(r_block) << 4) + 32'(r_cnt) - 32'd1;
    assign w_rd_idx        = (32'(r_block) << 4) + 32'(r_cnt) + 32'd1;
    assign w_total         = 32'(r_nblocks) << 4;
    assign w_len           = 64'(r_num_words) << 5;
    assign w_next_block    = r_block + ADDR_W'(1);
    assign w_next_base     = 32'(w_next_block) << 4;
    assign w_start_nblocks = ADDR_W'((32'(num_words) + 32'd18) >> 4);

    // Padded word i: message data, then the 0x80 marker, then zeros, then the 64-bit length.
    always_comb begin
        w_pad = 32'h0;
        if (w_cap_idx < w_nw) begin
            w_pad = mem_read_data;
        end else if (w_cap_idx == w_nw) begin
            w_pad = 32'h8000_0000;
        end else if (w_cap_idx == w_total - 32'd1) begin
            w_pad = w_len[31:0];
        end else if (w_cap_idx == w_total - 32'd2) begin
            w_pad = w_len[63:32];
        end
    end

    always_comb begin
        w_h_sum = '0;
        for (int k = 0; k < 8; k++) begin
            w_h_sum[32*k +: 32] = r_h[32*k +: 32] + r_s[32*k +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_block     <= '0;
            r_nblocks   <= '0;
            r_msg_addr  <= '0;
            r_out_addr  <= '0;
            r_num_words <= '0;
            r_h         <= '0;
            r_s         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            for (int k = 0; k < 16; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state     <= StLoad;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_block     <= '0;
                        r_nblocks   <= w_start_nblocks;
                        r_msg_addr  <= message_addr;
                        r_out_addr  <= output_addr;
                        r_num_words <= num_words;
                        r_h         <= use_iv ? iv_in : STD_IV;
                        r_s         <= use_iv ? iv_in : STD_IV;
                        if (num_words != '0) begin
                            r_addr <= message_addr;
                        end
                    end
                end
                StLoad: begin
                    // Read data lags its address by one cycle, so capture trails issue.
                    if (r_cnt != 6'd0) begin
                        for (int k = 0; k < 15; k++) begin
                            r_w[k] <= r_w[k+1];
                        end
                        r_w[15] <= w_pad;
                    end
                    if (r_cnt < 6'd15 && w_rd_idx < w_nw) begin
                        r_addr <= ADDR_W'(32'(r_msg_addr) + w_rd_idx);
                    end
                    if (r_cnt == 6'd16) begin
                        r_state <= StCompute;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                StCompute: begin
                    r_s <= w_round_out;
                    for (int k = 0; k < 15; k++) begin
                        r_w[k] <= r_w[k+1];
                    end
                    r_w[15] <= w_w_next;
                    if (r_cnt == 6'd63) begin
                        r_state <= StAccum;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                StAccum: begin
                    r_h <= w_h_sum;
                    r_s <= w_h_sum;
                    r_cnt <= '0;
                    if (w_next_block < r_nblocks) begin
                        r_state <= StLoad;
                        r_block <= w_next_block;
                        if (w_next_base < w_nw) begin
                            r_addr <= ADDR_W'(32'(r_msg_addr) + w_next_base);
                        end
                    end else begin
                        r_state <= StWrite;
                        r_we    <= 1'b1;
                        r_addr  <= r_out_addr;
                        r_wdata <= w_h_sum[255:224];
                    end
                end
                StWrite: begin
                    if (r_cnt == 6'd7) begin
                        r_state <= StDone;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        // Rotate H so the next word to write is always at the top.
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_wdata <= r_h[223:192];
                        r_h     <= {r_h[223:0], r_h[255:224]};
                        r_cnt   <= r_cnt + 6'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Directed bench for sha256_multiblock: known-answer digests, a software SHA-256 model,
// cycle-exact done timing, and start/reset control corner cases.
module tb_sha256_multiblock;

    localparam int AW = 16;

    localparam logic [255:0] IV0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_ABCD =
        256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int           nw;
        int           msg;
        int           out;
        bit           use_iv;
        logic [255:0] iv;
        logic [255:0] exp;
        int           exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] message_addr;
    logic [AW-1:0] output_addr;
    logic [AW-1:0] num_words;
    logic          use_iv;
    logic [255:0]  iv_in;
    logic          busy;
    logic          done;
    logic          mem_clk;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    logic [31:0]   mem  [65536];
    logic [31:0]   wmem [65536];
    logic [AW-1:0] prev_addr = '0;
    int            cyc = 0;
    int            wr_count = 0;
    int            wr_win = 0;
    int            addr_moves = 0;
    int            n_checks = 0;
    int            n_err = 0;

    vec_t          vecs [9];
    logic [255:0]  mid;
    logic [511:0]  blk0;

    sha256_multiblock #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .num_words      (num_words),
        .use_iv         (use_iv),
        .iv_in          (iv_in),
        .busy           (busy),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory; DUT writes land in wmem, message data is only ever read from mem.
    always @(posedge clk) begin
        cyc           <= cyc + 1;
        mem_read_data <= mem[mem_addr];
        prev_addr     <= mem_addr;
        if (mem_we) begin
            wmem[mem_addr] <= mem_write_data;
            wr_count       <= wr_count + 1;
            if (mem_addr >= 16'd1000 && mem_addr <= 16'd1007) wr_win <= wr_win + 1;
        end else if (mem_addr != prev_addr) begin
            addr_moves <= addr_moves + 1;
        end
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] sw_sha(input int msg, input int nw, input logic [255:0] iv);
        logic [255:0] hv;
        logic [511:0] blk;
        logic [31:0]  wd;
        int           nb;
        int           idx;
        hv = iv;
        nb = 1;
        while (nb * 16 < nw + 3) nb++;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 16; j++) begin
                idx = b * 16 + j;
                if (idx < nw) wd = mem[(msg + idx) % 65536];
                else if (idx == nw) wd = 32'h8000_0000;
                else if (idx == nb * 16 - 1) wd = 32'(nw * 32);
                else wd = 32'h0;
                blk[511-32*j -: 32] = wd;
            end
            hv = compress(hv, blk);
        end
        return hv;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input vec_t v, output int t0);
        @(negedge clk);
        message_addr = 16'(v.msg);
        output_addr  = 16'(v.out);
        num_words    = 16'(v.nw);
        use_iv       = v.use_iv;
        iv_in        = v.iv;
        start        = 1'b1;
        t0           = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int glitch_at);
        int           t0;
        int           dc;
        int           wc0;
        int           mv0;
        logic [255:0] dig;
        wc0 = wr_count;
        mv0 = addr_moves;
        launch(v, t0);
        check({tag, "_busy"}, 256'(busy), 256'(1));
        dc = -1;
        for (int n = 0; n < 400 && dc < 0; n++) begin
            if (done) begin
                dc = cyc - t0;
            end else begin
                if (cyc - t0 == glitch_at) begin
                    start        = 1'b1;
                    message_addr = 16'd300;
                    output_addr  = 16'd1500;
                    num_words    = 16'd0;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        check({tag, "_done_cycle"}, 256'(dc), 256'(v.exp_done));
        @(negedge clk);
        check({tag, "_idle_after"}, 256'({busy, done}), 256'(0));
        for (int k = 0; k < 8; k++) dig[255-32*k -: 32] = wmem[(v.out + k) % 65536];
        check({tag, "_digest"}, dig, v.exp);
        check({tag, "_write_count"}, 256'(wr_count - wc0), 256'(8));
        if (v.nw == 0) check({tag, "_no_read"}, 256'(addr_moves - mv0), 256'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        int   wv0;
        int   seen;
        vec_t g;

        reset        = 1'b1;
        start        = 1'b0;
        message_addr = '0;
        output_addr  = '0;
        num_words    = '0;
        use_iv       = 1'b0;
        iv_in        = '0;

        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[0] = 32'h0123_4567;
        for (int i = 1; i < 19; i++) mem[i] = {mem[i-1][30:0], mem[i-1][31]};
        mem[19] = 32'h0;
        mem[200] = 32'h6162_6364;
        for (int i = 0; i < 6; i++) mem[65530 + i] = 32'ha5a5_0000 + 32'(i);
        for (int i = 0; i < 16; i++) blk0[511-32*i -: 32] = mem[i];
        mid = compress(IV0, blk0);

        vecs[0] = '{0,  300,   1200, 1'b0, 256'h0, DIG_EMPTY,               91};
        vecs[1] = '{1,  200,   1208, 1'b0, 256'h0, DIG_ABCD,                91};
        vecs[2] = '{20, 0,     1000, 1'b0, 256'h0, sw_sha(0, 20, IV0),      173};
        vecs[3] = '{13, 0,     1216, 1'b0, 256'h0, sw_sha(0, 13, IV0),      91};
        vecs[4] = '{14, 0,     1224, 1'b0, 256'h0, sw_sha(0, 14, IV0),      173};
        vecs[5] = '{1,  200,   1232, 1'b1, IV0,    DIG_ABCD,                91};
        vecs[6] = '{4,  16,    1240, 1'b1, mid,    sw_sha(16, 4, mid),      91};
        vecs[7] = '{10, 65530, 1248, 1'b0, 256'h0, sw_sha(65530, 10, IV0),  91};
        vecs[8] = '{29, 0,     1256, 1'b0, 256'h0, sw_sha(0, 29, IV0),      173};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_we", 256'(mem_we), 256'(0));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_wdata", 256'(mem_write_data), 256'(0));
        check("mem_clk", 256'(mem_clk), 256'(clk));

        for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i], 0);

        // A start pulse mid-run with different inputs must be ignored.
        g = '{20, 0, 1300, 1'b0, 256'h0, sw_sha(0, 20, IV0), 173};
        run_vec("glitch", g, 50);

        // Reset during block 1 compute: outputs clear next cycle and no digest is written.
        wv0 = wr_win;
        g = '{20, 0, 1000, 1'b0, 256'h0, sw_sha(0, 20, IV0), 173};
        launch(g, t0);
        while (cyc - t0 < 100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_done", 256'(done), 256'(0));
        check("midrst_we", 256'(mem_we), 256'(0));
        check("midrst_addr", 256'(mem_addr), 256'(0));
        reset = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (done || mem_we) seen++;
        end
        check("midrst_quiet", 256'(seen), 256'(0));
        check("midrst_no_write", 256'(wr_win - wv0), 256'(0));

        g = '{20, 0, 1400, 1'b0, 256'h0, sw_sha(0, 20, IV0), 173};
        run_vec("post_rst", g, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
